// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo counter controller: FSM state encoding
// and the default counter width.
package mod_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mod_counter_ctrl_tff.sv
// Toggle flip-flop cell: q flips when t is high, synchronous active-high reset.
module tff (
  input  logic clk,
  input  logic t,
  input  logic rst,
  output logic q,
  output logic qb
);

  // Toggle storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/mod_counter_ctrl.sv
// Modulo up/down counter controller. A three-state FSM (IDLE/RUN/HOLD) decides
// when the count steps or loads; the count itself lives in a row of toggle
// cells driven by t = next ^ count, so there is no direct load path.
//
// Handshake: none. start/stop/load are level-sampled every rising edge; stop
// beats start in every state, and a RUN cycle with stop=1 does not step.
module mod_counter_ctrl
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic [WIDTH-1:0] mod_n,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output state_t           o_dbg_state
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_tc;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_toggle;
  logic             w_wrap;

  // State register plus the registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tc    <= w_wrap;
      r_done  <= w_wrap & one_shot;
      r_busy  <= (w_state_next == RUN);
    end
  end

  // Next-state decision; stop always wins over start.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start && !stop) w_state_next = RUN;
      RUN: begin
        if (stop) begin
          w_state_next = HOLD;
        end else if (w_wrap && one_shot) begin
          w_state_next = IDLE;
        end
      end
      HOLD: if (start && !stop) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // Next count value and wrap detection; loads only outside RUN.
  always_comb begin
    w_next = w_count;
    w_wrap = 1'b0;
    if (r_state != RUN) begin
      if (load) w_next = load_val;
    end else if (!stop) begin
      if (up) begin
        if (w_count < mod_n) begin
          w_next = w_count + WIDTH'(1);
        end else begin
          w_next = '0;
          w_wrap = 1'b1;
        end
      end else begin
        if ((w_count != '0) && (w_count <= mod_n)) begin
          w_next = w_count - WIDTH'(1);
        end else begin
          w_next = mod_n;
          w_wrap = 1'b1;
        end
      end
    end
  end

  assign w_toggle = w_next ^ w_count;

  // One toggle cell per count bit; the complement output is not needed.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    tff u_tff (
      .clk (clk),
      .t   (w_toggle[gi]),
      .rst (rst),
      .q   (w_count[gi]),
      .qb  ()
    );
  end

  assign count       = w_count;
  assign tc          = r_tc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Self-checking bench for mod_counter_ctrl: directed scenarios followed by
// random stimulus, all compared against a cycle-level behavioural model.
module tb_mod_counter_ctrl;
  import mod_counter_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         load;
  logic [W-1:0] load_val;
  logic         up;
  logic [W-1:0] mod_n;
  logic         one_shot;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: 0=idle, 1=run, 2=hold
  int m_cnt  = 0;
  int m_st   = 0;
  int m_tc   = 0;
  int m_done = 0;
  int m_busy = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mod_counter_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .load        (load),
    .load_val    (load_val),
    .up          (up),
    .mod_n       (mod_n),
    .one_shot    (one_shot),
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic model_step();
    int n;
    n = int'(mod_n);
    if (rst) begin
      m_cnt = 0; m_st = 0; m_tc = 0; m_done = 0;
    end else begin
      m_tc = 0; m_done = 0;
      if (m_st == 1) begin
        if (stop) begin
          m_st = 2;
        end else begin
          if (up) begin
            if (m_cnt < n) m_cnt = m_cnt + 1;
            else begin m_cnt = 0; m_tc = 1; end
          end else begin
            if (m_cnt > 0 && m_cnt <= n) m_cnt = m_cnt - 1;
            else begin m_cnt = n; m_tc = 1; end
          end
          if (m_tc == 1 && one_shot) begin
            m_done = 1;
            m_st   = 0;
          end
        end
      end else begin
        if (load) m_cnt = int'(load_val);
        if (start && !stop) m_st = 1;
      end
    end
    m_busy = (m_st == 1) ? 1 : 0;
  endtask

  // One clock: edge, model update, sample outputs away from the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("count", 32'(count), 32'(m_cnt));
    chk("tc",    32'(tc),    32'(m_tc));
    chk("busy",  32'(busy),  32'(m_busy));
    chk("done",  32'(done),  32'(m_done));
    chk("state", 32'(dbg_state), 32'(m_st));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
    load_val = '0; up = 1'b1; mod_n = 4'd5; one_shot = 1'b0;

    // reset state
    cycles(2);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);

    // up-count with wrap at 5
    rst = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cycles(5);
    chk("up_top", 32'(count), 32'd5);
    cyc();
    chk("up_wrap_cnt", 32'(count), 32'd0);
    chk("up_wrap_tc",  32'(tc),    32'd1);
    cyc();

    // pause, then down-count with load+start
    stop = 1'b1;
    cyc();
    stop = 1'b0; load = 1'b1; load_val = 4'd3; up = 1'b0; mod_n = 4'd9; start = 1'b1;
    cyc();
    chk("dn_first", 32'(count), 32'd3);
    load = 1'b0; start = 1'b0;
    cycles(3);
    cyc();
    chk("dn_wrap_cnt", 32'(count), 32'd9);
    chk("dn_wrap_tc",  32'(tc),    32'd1);
    cyc();

    // one-shot
    rst = 1'b1;
    cyc();
    rst = 1'b0; mod_n = 4'd2; up = 1'b1; one_shot = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cycles(2);
    cyc();
    chk("os_done", 32'(done), 32'd1);
    chk("os_busy", 32'(busy), 32'd0);
    cycles(2);
    chk("os_hold", 32'(count), 32'd0);

    // pause with stop+start, then resume
    one_shot = 1'b0; mod_n = 4'd9; start = 1'b1;
    cyc();
    start = 1'b0;
    cycles(4);
    stop = 1'b1; start = 1'b1;
    cycles(3);
    chk("pause_cnt", 32'(count), 32'd4);
    chk("pause_st",  32'(dbg_state), 32'(HOLD));
    stop = 1'b0;
    cycles(2);
    chk("resume", 32'(count), 32'd5);

    // out-of-range load in HOLD
    stop = 1'b1; start = 1'b0;
    cyc();
    stop = 1'b0; load = 1'b1; load_val = 4'd12; mod_n = 4'd7;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("oor_cnt", 32'(count), 32'd0);
    chk("oor_tc",  32'(tc),    32'd1);

    // reset mid-run with load asserted
    cycles(6);
    chk("pre_rst", 32'(count), 32'd6);
    rst = 1'b1; load = 1'b1; load_val = 4'd9;
    cyc();
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_tc",  32'(tc),    32'd0);
    rst = 1'b0; load = 1'b0;

    // randomized stimulus
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 2) == 0);
      stop     = ($urandom_range(0, 5) == 0);
      load     = ($urandom_range(0, 4) == 0);
      load_val = W'($urandom_range(0, 15));
      up       = ($urandom_range(0, 3) != 0);
      one_shot = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) mod_n = W'($urandom_range(0, 15));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
